// File: rtl/exe_out_stage.sv
// exe_out_stage: registered output stage behind the conversion logic.
// A 2-entry skid buffer (OUT + SKID) sits behind a valid/ready handshake.
// Each word carries {P,E,Z,N} status flags.
// A saturating error counter and a sticky error flag are also kept.
// Optional feature macro: EXE_OUT_PARITY_EN. When it is defined, o_status[3]
// carries the even parity of the word; otherwise o_status[3] is tied to 0.
module exe_out_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_result,
  input  logic              i_error,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_result,
  output logic [3:0]        o_status,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_err_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] out_res_q, skid_res_q;
  logic [2:0]       out_st_q, skid_st_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;

  logic             in_xfer, out_xfer;
  logic             out_free;
  logic             out_ld_skid, out_ld_in, skid_ld;
  logic [2:0]       in_st;

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = out_vld_q & i_ready;
  assign out_free = ~out_vld_q | out_xfer;

  // SKID always drains first; a new word cannot arrive then since o_ready=0.
  assign out_ld_skid = out_free & skid_vld_q;
  assign out_ld_in   = out_free & ~skid_vld_q & in_xfer;
  assign skid_ld     = ~out_free & in_xfer;

  // Flags {E, Z, N}; an errored word is never reported as negative.
  assign in_st = {i_error, (i_result == '0), i_result[WIDTH-1] & ~i_error};

  // Next-state for occupancy and the error counter / sticky flag.
  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_xfer;
      end
    end else if (in_xfer) begin
      skid_vld_d = 1'b1;
    end
    if (i_clr_cnt) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (in_xfer && i_error) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control state and the visible OUT register, cleared on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      out_res_q  <= '0;
      out_st_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      if (out_ld_skid) begin
        out_res_q <= skid_res_q;
        out_st_q  <= skid_st_q;
      end else if (out_ld_in) begin
        out_res_q <= i_result;
        out_st_q  <= in_st;
      end
    end
  end

  // SKID payload; it is only observed when skid_vld_q is set.
  always_ff @(posedge i_clk) begin
    if (skid_ld) begin
      skid_res_q <= i_result;
      skid_st_q  <= in_st;
    end
  end

`ifdef EXE_OUT_PARITY_EN
  logic in_par;
  logic out_par_q, skid_par_q;

  assign in_par = ^i_result;

  // Parity bit stored alongside each entry, following the same moves as the data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_par_q <= 1'b0;
    end else if (out_ld_skid) begin
      out_par_q <= skid_par_q;
    end else if (out_ld_in) begin
      out_par_q <= in_par;
    end
  end

  // SKID parity bit.
  always_ff @(posedge i_clk) begin
    if (skid_ld) begin
      skid_par_q <= in_par;
    end
  end

  assign o_status = {out_par_q, out_st_q};
`else
  assign o_status = {1'b0, out_st_q};
`endif

  assign o_ready      = ~skid_vld_q;
  assign o_valid      = out_vld_q;
  assign o_result     = out_res_q;
  assign o_err_cnt    = cnt_q;
  assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_exe_out_stage.sv
// Testbench for exe_out_stage.
// It runs a directed vector table first, then randomized traffic that is
// checked against a queue-based reference model. A second instance with
// CNT_W=2 exercises counter saturation.
module tb_exe_out_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_error, i_ready, i_clr_cnt;
  logic [31:0] i_result;
  logic        o_ready, o_valid, o_err_sticky;
  logic [31:0] o_result;
  logic [3:0]  o_status;
  logic [7:0]  o_err_cnt;
  logic        o_ready2, o_valid2, o_err_sticky2;
  logic [31:0] o_result2;
  logic [3:0]  o_status2;
  logic [1:0]  o_err_cnt2;

  always #5 i_clk = ~i_clk;

  exe_out_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_result(i_result), .i_error(i_error), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_status(o_status), .i_clr_cnt(i_clr_cnt),
    .o_err_cnt(o_err_cnt), .o_err_sticky(o_err_sticky)
  );

  exe_out_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready2),
    .i_result(i_result), .i_error(i_error), .o_valid(o_valid2), .i_ready(i_ready),
    .o_result(o_result2), .o_status(o_status2), .i_clr_cnt(i_clr_cnt),
    .o_err_cnt(o_err_cnt2), .o_err_sticky(o_err_sticky2)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] r;
    bit          e;
  } ent_t;

  ent_t mq[$];
  int   m_cnt, m_cnt2;
  bit   m_stk;

  typedef struct {
    bit          rst, v;
    logic [31:0] r;
    bit          e, rdy, clr;
    bit          ev, er;
    logic [31:0] eres;
    logic [2:0]  est;
    logic [7:0]  ecnt;
    bit          estk;
  } vec_t;

  vec_t tbl[$];

  function automatic bit exp_p(input logic [31:0] r);
`ifdef EXE_OUT_PARITY_EN
    return ^r;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_stat(input ent_t x);
    return {exp_p(x.r), x.e, x.r == 32'd0, x.r[31] & ~x.e};
  endfunction

  function automatic vec_t mk(input bit rst, v, input logic [31:0] r, input bit e, rdy, clr,
                              input bit ev, er, input logic [31:0] eres,
                              input logic [2:0] est, input logic [7:0] ecnt, input bit estk);
    vec_t t;
    t.rst = rst; t.v = v; t.r = r; t.e = e; t.rdy = rdy; t.clr = clr;
    t.ev = ev; t.er = er; t.eres = eres; t.est = est; t.ecnt = ecnt; t.estk = estk;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs; the reference model advances on the same edge.
  task automatic step(input bit rst, v, input logic [31:0] r, input bit e, rdy, clr);
    bit acc, pop;
    ent_t x;
    i_rst = rst; i_valid = v; i_result = r; i_error = e; i_ready = rdy; i_clr_cnt = clr;
    @(posedge i_clk);
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_cnt2 = 0; m_stk = 0;
    end else begin
      acc = v && (mq.size() < 2);
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        x.r = r; x.e = e;
        mq.push_back(x);
      end
      if (clr) begin
        m_cnt = 0; m_cnt2 = 0; m_stk = 0;
      end else if (acc && e) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        m_stk  = 1;
      end
    end
    #1;
  endtask

  task automatic model_check();
    chk("m_valid", {63'd0, o_valid}, {63'd0, mq.size() > 0});
    chk("m_ready", {63'd0, o_ready}, {63'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk("m_result", {32'd0, o_result}, {32'd0, mq[0].r});
      chk("m_status", {60'd0, o_status}, {60'd0, exp_stat(mq[0])});
      chk("m2_flow", {o_valid2, o_ready2, o_status2, o_result2},
          {1'b1, mq.size() < 2, exp_stat(mq[0]), mq[0].r});
    end
    chk("m_cnt", {56'd0, o_err_cnt}, m_cnt);
    chk("m_sticky", {63'd0, o_err_sticky}, {63'd0, m_stk});
    chk("m2_cnt", {62'd0, o_err_cnt2}, m_cnt2);
    chk("m2_sticky", {63'd0, o_err_sticky2}, {63'd0, m_stk});
  endtask

  initial begin
    vec_t t;
    logic [31:0] w;
    bit          e;
    logic [7:0]  c2;

    // rst v  result         e rdy clr | ev er eres          est     cnt stk
    tbl.push_back(mk(1,0,32'h0,         0,0,0, 0,1,32'h0,         3'b000, 0,0));
    tbl.push_back(mk(0,1,32'h0000_0005, 0,1,0, 1,1,32'h0000_0005, 3'b000, 0,0));
    tbl.push_back(mk(0,1,32'h8000_0003, 0,1,0, 1,1,32'h8000_0003, 3'b001, 0,0));
    tbl.push_back(mk(0,1,32'h0000_0000, 0,0,0, 1,0,32'h8000_0003, 3'b001, 0,0));
    tbl.push_back(mk(0,1,32'h0000_1234, 0,0,0, 1,0,32'h8000_0003, 3'b001, 0,0));
    tbl.push_back(mk(0,0,32'h0,         0,1,0, 1,1,32'h0000_0000, 3'b010, 0,0));
    tbl.push_back(mk(0,0,32'h0,         0,1,0, 0,1,32'h0,         3'b000, 0,0));
    tbl.push_back(mk(0,1,32'h8000_0000, 1,0,0, 1,1,32'h8000_0000, 3'b100, 1,1));
    tbl.push_back(mk(0,0,32'h0,         0,1,0, 0,1,32'h0,         3'b000, 1,1));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0,1,32'(i),      1,1,0, 1,1,32'(i),        3'b100, 8'(i + 1),1));
    tbl.push_back(mk(0,1,32'h0000_0007, 1,1,1, 1,1,32'h0000_0007, 3'b100, 0,0));
    tbl.push_back(mk(0,1,32'h0000_0007, 0,1,0, 1,1,32'h0000_0007, 3'b000, 0,0));
    tbl.push_back(mk(0,1,32'h0000_0003, 0,1,0, 1,1,32'h0000_0003, 3'b000, 0,0));
    tbl.push_back(mk(0,0,32'h0,         0,1,0, 0,1,32'h0,         3'b000, 0,0));
    tbl.push_back(mk(0,1,32'hA5A5_0000, 0,0,0, 1,1,32'hA5A5_0000, 3'b001, 0,0));
    tbl.push_back(mk(0,1,32'h0000_1111, 0,0,0, 1,0,32'hA5A5_0000, 3'b001, 0,0));
    tbl.push_back(mk(1,0,32'h0,         0,0,0, 0,1,32'h0,         3'b000, 0,0));

    foreach (tbl[k]) begin
      t = tbl[k];
      step(t.rst, t.v, t.r, t.e, t.rdy, t.clr);
      chk($sformatf("t%0d_valid", k), {63'd0, o_valid}, {63'd0, t.ev});
      chk($sformatf("t%0d_ready", k), {63'd0, o_ready}, {63'd0, t.er});
      if (t.ev || t.rst) begin
        chk($sformatf("t%0d_result", k), {32'd0, o_result}, {32'd0, t.eres});
        chk($sformatf("t%0d_status", k), {60'd0, o_status},
            {60'd0, t.rst ? 1'b0 : exp_p(t.eres), t.est});
      end
      chk($sformatf("t%0d_cnt", k), {56'd0, o_err_cnt}, {56'd0, t.ecnt});
      chk($sformatf("t%0d_sticky", k), {63'd0, o_err_sticky}, {63'd0, t.estk});
      c2 = (t.ecnt > 3) ? 8'd3 : t.ecnt;
      chk($sformatf("t%0d_cnt2", k), {62'd0, o_err_cnt2}, {56'd0, c2});
    end

    // Back-to-back streaming: one word per cycle, o_ready never drops.
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      e = ($urandom_range(0, 7) == 0);
      step(0, 1, w, e, 1, 0);
      chk("stream_ready", {63'd0, o_ready}, 64'd1);
      chk("stream_valid", {63'd0, o_valid}, 64'd1);
      chk("stream_word", {32'd0, o_result}, {32'd0, w});
      model_check();
    end

    // Fill OUT and SKID, then reset with SKID full.
    step(0, 1, 32'h1111_2222, 0, 0, 0);
    step(0, 1, 32'h3333_4444, 0, 0, 0);
    chk("skid_full_ready", {63'd0, o_ready}, 64'd0);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("rst_full_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_full_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_full_result", {32'd0, o_result}, 64'd0);

    // Randomized traffic with stalls, errors and counter clears.
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step(0, $urandom_range(0, 3) != 0, w, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
